// File: rtl/glyph_renderer_if.sv
// Pixel-stream bundle between the VGA timing generator, the 3x5 character
// memory read port and the glyph renderer.
//
// Stream semantics: there is no valid/ready pair. Every clock carries one
// pixel. de_in marks active video. The renderer never stalls, and its outputs
// follow their inputs by a fixed latency. mem_x/mem_y/mem_data form a
// read-only port into the character memory.
interface glyph_renderer_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] mem_x;
  logic [2:0] mem_y;
  logic       mem_data;
  logic [5:0] rgb;
  logic       de_out;
  logic       hsync_out;
  logic       vsync_out;

  // Environment side: timing generator, memory read data, display sink.
  modport master (
    output hpos, vpos, de_in, hsync_in, vsync_in, mem_data,
    input  mem_x, mem_y, rgb, de_out, hsync_out, vsync_out
  );

  // Renderer side.
  modport slave (
    input  hpos, vpos, de_in, hsync_in, vsync_in, mem_data,
    output mem_x, mem_y, rgb, de_out, hsync_out, vsync_out
  );
endinterface

// File: rtl/glyph_renderer.sv
// Glyph renderer: maps beam coordinates onto a scaled 3x5 glyph box and
// drives the character memory read address. Row is presented one cycle ahead
// of column, because the memory latches y one edge before x. The renderer
// emits an RRGGBB pixel with sync and de delayed by the same 4 cycles.
module glyph_renderer #(
  parameter logic [9:0] ORIGIN_X   = 10'd16,
  parameter logic [9:0] ORIGIN_Y   = 10'd8,
  parameter int         SCALE_LOG2 = 3,
  parameter logic [5:0] FG_COLOR   = 6'b111111,
  parameter logic [5:0] BG_COLOR   = 6'b000001
) (
  input logic             clock,
  input logic             rst_n,
  glyph_renderer_if.slave bus
);

  // Offsets are one bit wider than the beam counters. Bit 10 set means the
  // beam is above or left of the box.
  logic [10:0] dx;
  logic [10:0] dy;
  logic [9:0]  col_full;
  logic [9:0]  row_full;
  logic        in_box;

  assign dx = {1'b0, bus.hpos} - {1'b0, ORIGIN_X};
  assign dy = {1'b0, bus.vpos} - {1'b0, ORIGIN_Y};

  // Keep the full-width cell index so the bound checks see the real value.
  assign col_full = dx[9:0] >> SCALE_LOG2;
  assign row_full = dy[9:0] >> SCALE_LOG2;

  assign in_box = bus.de_in & ~dx[10] & ~dy[10]
                & (col_full < 10'd3) & (row_full < 10'd5);

  // Stage 1: row address goes out at once. Column and flags wait one cycle.
  logic [2:0] mem_y_q;
  logic [1:0] s1_col;
  logic       s1_in_box;
  logic       s1_de;
  logic       s1_hsync;
  logic       s1_vsync;

  // Stage 1 registers: row address leads, everything else is captured.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      mem_y_q   <= 3'd0;
      s1_col    <= 2'd0;
      s1_in_box <= 1'b0;
      s1_de     <= 1'b0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
    end else begin
      mem_y_q   <= in_box ? row_full[2:0] : 3'd0;
      s1_col    <= in_box ? col_full[1:0] : 2'd0;
      s1_in_box <= in_box;
      s1_de     <= bus.de_in;
      s1_hsync  <= bus.hsync_in;
      s1_vsync  <= bus.vsync_in;
    end
  end

  // Stage 2: column address, one cycle behind its row.
  logic [1:0] mem_x_q;
  logic       s2_in_box;
  logic       s2_de;
  logic       s2_hsync;
  logic       s2_vsync;

  // Stage 2 registers: column address follows the row by one edge.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      mem_x_q   <= 2'd0;
      s2_in_box <= 1'b0;
      s2_de     <= 1'b0;
      s2_hsync  <= 1'b1;
      s2_vsync  <= 1'b1;
    end else begin
      mem_x_q   <= s1_in_box ? s1_col : 2'd0;
      s2_in_box <= s1_in_box;
      s2_de     <= s1_de;
      s2_hsync  <= s1_hsync;
      s2_vsync  <= s1_vsync;
    end
  end

  // Stage 3: wait while the memory registers the addressed bit.
  logic s3_in_box;
  logic s3_de;
  logic s3_hsync;
  logic s3_vsync;

  // Stage 3 registers: pure delay matching the memory read latency.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      s3_in_box <= 1'b0;
      s3_de     <= 1'b0;
      s3_hsync  <= 1'b1;
      s3_vsync  <= 1'b1;
    end else begin
      s3_in_box <= s2_in_box;
      s3_de     <= s2_de;
      s3_hsync  <= s2_hsync;
      s3_vsync  <= s2_vsync;
    end
  end

  // Colour selection for the pixel whose memory bit is now on mem_data.
  logic [5:0] pixel;

  // Blank outside active video, background outside the box or on clear bits.
  always_comb begin
    pixel = 6'b0;
    if (s3_de) begin
      pixel = (s3_in_box && bus.mem_data) ? FG_COLOR : BG_COLOR;
    end
  end

  // Stage 4: output registers.
  logic [5:0] rgb_q;
  logic       de_q;
  logic       hsync_q;
  logic       vsync_q;

  // Output registers: sync idles high and video is blank in reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      rgb_q   <= 6'b0;
      de_q    <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      rgb_q   <= pixel;
      de_q    <= s3_de;
      hsync_q <= s3_hsync;
      vsync_q <= s3_vsync;
    end
  end

  assign bus.mem_y     = mem_y_q;
  assign bus.mem_x     = mem_x_q;
  assign bus.rgb       = rgb_q;
  assign bus.de_out    = de_q;
  assign bus.hsync_out = hsync_q;
  assign bus.vsync_out = vsync_q;

endmodule

// File: tb/tb_glyph_renderer.sv
// Bench for glyph_renderer: a behavioural char memory with the row/column
// skew, a 4-deep expected queue filled as pixels are driven, and a directed
// sequence of sweeps, reset, sync and random pixels.
module tb_glyph_renderer;

  localparam logic [5:0] FG = 6'b111111;
  localparam logic [5:0] BG = 6'b000001;
  // {check_sync, rgb[5:0], de, hsync, vsync}; sync is not checked while the
  // pipeline refills after reset.
  localparam logic [9:0] RST_ENTRY = {1'b0, 6'b0, 1'b0, 1'b1, 1'b1};

  logic clock = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   bound_viol = 0;

  logic [9:0]  exp_q[$];
  logic [14:0] bitmap = 15'h5555;
  logic [2:0]  lat_row = 3'd0;

  glyph_renderer_if vif ();

  glyph_renderer dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (vif)
  );

  // Clock and reset block.
  always #5 clock = ~clock;

  // Memory bit lookup. Rows 5..7 hold stale ones and column 3 reads 0.
  function automatic logic mem_bit(input logic [2:0] row, input logic [1:0] col);
    if (row > 3'd4) return 1'b1;
    if (col == 2'd3) return 1'b0;
    return bitmap[int'(row) * 3 + int'(col)];
  endfunction

  // Char memory: row latched on one edge, bit registered on the next.
  always @(posedge clock) begin
    vif.mem_data <= mem_bit(lat_row, vif.mem_x);
    lat_row      <= vif.mem_y;
  end

  // Address-range watch over the whole run.
  always @(negedge clock) begin
    if ((vif.mem_y > 3'd4) === 1'b1 || (vif.mem_x == 2'd3) === 1'b1)
      bound_viol++;
  end

  // Reference model of one pixel, written from box geometry in plain integers.
  function automatic logic [9:0] model(input logic [9:0] h, input logic [9:0] v,
                                       input logic de, input logic hs, input logic vs);
    int dx, dy;
    logic inb;
    logic [5:0] c;
    dx  = int'(h) - 16;
    dy  = int'(v) - 8;
    inb = de && dx >= 0 && dx < 24 && dy >= 0 && dy < 40;
    if (!de) c = 6'b0;
    else if (inb && bitmap[(dy / 8) * 3 + (dx / 8)]) c = FG;
    else c = BG;
    return {1'b1, c, de, hs, vs};
  endfunction

  // Driver: check the output due now, then drive one pixel and queue its result.
  task automatic tick(input logic [9:0] h, input logic [9:0] v, input logic de,
                      input logic hs, input logic vs, input logic rst);
    logic [9:0] e;
    if (exp_q.size() >= 4) begin
      e = exp_q.pop_front();
      n_assert++;
      assert (vif.rgb === e[8:3]) else begin
        n_fail++;
        $error("FAIL rgb obs=%b exp=%b t=%0t", vif.rgb, e[8:3], $time);
      end
      n_assert++;
      assert (vif.de_out === e[2]) else begin
        n_fail++;
        $error("FAIL de_out obs=%b exp=%b t=%0t", vif.de_out, e[2], $time);
      end
      if (e[9]) begin
        n_assert++;
        assert ({vif.hsync_out, vif.vsync_out} === e[1:0]) else begin
          n_fail++;
          $error("FAIL sync obs=%b exp=%b t=%0t", {vif.hsync_out, vif.vsync_out}, e[1:0], $time);
        end
      end
    end
    if (!rst) begin
      foreach (exp_q[i]) exp_q[i] = RST_ENTRY;
    end
    rst_n        = rst;
    vif.hpos     = h;
    vif.vpos     = v;
    vif.de_in    = de;
    vif.hsync_in = hs;
    vif.vsync_in = vs;
    exp_q.push_back(rst ? model(h, v, de, hs, vs) : RST_ENTRY);
    @(negedge clock);
  endtask

  // One line of active video across hpos 0..63.
  task automatic sweep(input logic [9:0] v);
    for (int i = 0; i < 64; i++) tick(10'(i), v, 1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n        = 1'b0;
    vif.hpos     = 10'd0;
    vif.vpos     = 10'd0;
    vif.de_in    = 1'b0;
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    @(negedge clock);

    // Reset held: address and outputs at their idle values.
    for (int i = 0; i < 5; i++) tick(10'd20, 10'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    n_assert++;
    assert ({vif.mem_x, vif.mem_y} === 5'd0) else begin
      n_fail++;
      $error("FAIL reset_addr obs=%b exp=%b", {vif.mem_x, vif.mem_y}, 5'd0);
    end
    n_assert++;
    assert ({vif.rgb, vif.de_out, vif.hsync_out, vif.vsync_out} === 9'b000000_0_1_1) else begin
      n_fail++;
      $error("FAIL reset_out obs=%b exp=%b",
             {vif.rgb, vif.de_out, vif.hsync_out, vif.vsync_out}, 9'b000000_0_1_1);
    end

    // Row 0, then the line 15 -> 16 transition into row 1.
    sweep(10'd8);
    for (int i = 0; i < 4; i++) tick(10'd0, 10'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    sweep(10'd15);
    sweep(10'd16);

    // Bottom edge of the box.
    sweep(10'd47);
    sweep(10'd48);

    // Row changes between adjacent in-box pixels exercise the y lead.
    tick(10'd23, 10'd15, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(10'd24, 10'd16, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(10'd25, 10'd8,  1'b1, 1'b1, 1'b1, 1'b1);
    tick(10'd39, 10'd47, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(10'd16, 10'd8,  1'b1, 1'b1, 1'b1, 1'b1);

    // Blanked pixels inside the box.
    for (int i = 16; i < 40; i += 3) tick(10'(i), 10'd8, 1'b0, 1'b1, 1'b1, 1'b1);

    // Arbitrary sync pattern.
    for (int i = 0; i < 40; i++)
      tick(10'(i), 10'd20, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);

    // One-cycle reset in the middle of a line.
    for (int i = 0; i < 20; i++) tick(10'(i), 10'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    tick(10'd20, 10'd8, 1'b1, 1'b0, 1'b1, 1'b0);
    n_assert++;
    assert ({vif.rgb, vif.hsync_out, vif.vsync_out, vif.mem_x, vif.mem_y} === 13'b000000_1_1_00_000) else begin
      n_fail++;
      $error("FAIL midline_reset obs=%b exp=%b",
             {vif.rgb, vif.hsync_out, vif.vsync_out, vif.mem_x, vif.mem_y}, 13'b000000_1_1_00_000);
    end
    for (int i = 21; i < 64; i++) tick(10'(i), 10'd8, 1'b1, 1'b1, 1'b1, 1'b1);

    // Random pixels anywhere around the box.
    for (int i = 0; i < 300; i++)
      tick(10'($urandom_range(0, 63)), 10'($urandom_range(0, 63)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1);

    // Drain the pipeline.
    for (int i = 0; i < 4; i++) tick(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);

    n_assert++;
    assert (bound_viol === 0) else begin
      n_fail++;
      $error("FAIL mem_addr_range obs=%0d exp=%0d", bound_viol, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/glyph_renderer.md
# glyph_renderer

Pixel-pipeline stage that sits directly downstream of the 3×5 character bitmap memory in the VGA path. It takes raw beam coordinates and sync from the VGA timing generator and maps them onto a scaled glyph box. It drives the memory's read address with the row/column skew the memory's registered read path requires, and emits a colour pixel with delay-matched sync. Write-side access to the memory belongs to the host loader; this block only reads.

## Interface
- ORIGIN_X, 10'd16: left edge of the glyph box, in pixels.
- ORIGIN_Y, 10'd8: top edge of the glyph box, in lines.
- SCALE_LOG2, 3: each glyph cell spans 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels (range 0..5).
- FG_COLOR, 6'b111111: RRGGBB colour for set bits.
- BG_COLOR, 6'b000001: RRGGBB colour for clear bits and box-exterior active video.

Ports:
- clock  in  1  pixel clock.
- rst_n  in  1  synchronous, active-low reset.
- hpos  in  10  beam column.
- vpos  in  10  beam line.
- de_in  in  1  active-video flag.
- hsync_in, vsync_in  in  1 each  sync from the timing generator.
- mem_x  out  2  column address to the char memory; registered.
- mem_y  out  3  row address to the char memory; registered.
- mem_data  in  1  read data from the char memory.
- rgb  out  6  RRGGBB pixel; registered.
- de_out, hsync_out, vsync_out  out  1 each  delay-matched copies of the inputs.

## Operation
- Box geometry: S = 2^SCALE_LOG2. The box is hpos ∈ [ORIGIN_X, ORIGIN_X+3S) and vpos ∈ [ORIGIN_Y, ORIGIN_Y+5S).
- Offsets: dx = hpos − ORIGIN_X and dy = vpos − ORIGIN_Y, computed in 11 bits. A negative result (bit 10 set) means outside the box.
- Cell index: col = dx >> SCALE_LOG2 (0..2) and row = dy >> SCALE_LOG2 (0..4).
- in_box = de_in & both offsets non-negative & col < 3 & row < 5.
- Address when in_box: mem_x = col and mem_y = row. col 0 is the leftmost on-screen column; row 0 is the top.
- Address when !in_box: mem_x = 0 and mem_y = 0.
  - mem_y must never exceed 4: the memory holds stale row data for rows 5..7.
  - mem_x must never be 3: that column reads constant 0.
- Memory read skew: the memory latches the row selected by y on one edge and the column selected by x on the following edge. This block therefore presents mem_y for a pixel one cycle before mem_x for that same pixel.
- Output pixel:
  - rgb = FG_COLOR when in_box & mem_data.
  - rgb = BG_COLOR when in_box & !mem_data, or when de & !in_box.
  - rgb = 6'b0 when de = 0.
- Pipeline: 4 stages of shift registers carry in_box, de, hsync and vsync, so all outputs stay aligned.
- There is no state machine. Behaviour is a free-running pipeline with no stalls and no handshake.

## Timing
- Let pixel p present hpos/vpos/de/sync during cycle c.
- Edge c: mem_y ← row(p). Stage-1 registers ← col(p), in_box(p), de, hsync, vsync.
- Edge c+1: mem_x ← col(p). The memory latches row(p) internally.
- Edge c+2: the memory registers bit (row(p), col(p)) onto mem_data.
- Edge c+3: rgb, de_out, hsync_out and vsync_out for p are registered. These are valid during cycle c+4.
- Total input-to-output latency is exactly 4 cycles for all outputs.
- Consecutive pixels stream back-to-back, one per cycle.
- Row changes inside the box (for example at line ORIGIN_Y+S) must produce correct data on the first pixel of the new row, because of the one-cycle y lead.
- Box edges: the first in-box pixel (hpos = ORIGIN_X) and the last (hpos = ORIGIN_X+3S−1) both render. The pixel at hpos = ORIGIN_X+3S renders BG_COLOR.
- Reset values, held while rst_n = 0:
  - mem_x = 0 and mem_y = 0.
  - rgb = 0 and de_out = 0.
  - hsync_out = 1 and vsync_out = 1.
  - All pipeline stages clear.
- After rst_n rises, outputs reflect real input at edge 4.
- Reset asserted mid-frame forces the reset values at the next edge. No partial pixel escapes.

## Test plan
- Default parameters, memory at its reset pattern 0x5555, vpos = 8, sweep hpos 0..63 with de = 1 → rgb = 6'b111111 for hpos 16..23 and 32..39, 6'b000001 for 24..31 and for the remainder of active video. Each rgb value appears 4 cycles after its input.
- Same setup, vpos = 16 (row 1) → FG_COLOR for hpos 24..31 only. The transition from line 15 to line 16 shows no stale row-0 data on the first pixel.
- vpos = 47 then 48 → rows render up to line 47; line 48 gives BG_COLOR across the box x-range. mem_y never exceeds 4 during the whole sweep.
- de_in = 0 with hpos inside the box → rgb = 0, and de_out = 0 exactly 4 cycles later.
- Toggle hsync_in/vsync_in with an arbitrary pattern → hsync_out/vsync_out replicate it delayed by exactly 4 cycles.
- Assert rst_n = 0 mid-line for 1 cycle → the next edge shows rgb = 0, hsync_out = vsync_out = 1 and mem_x = mem_y = 0. Correct output resumes 4 cycles after release.
